// File: rtl/nibbler_pkg.sv
// Types shared across the Nibbler datapath: ALU, accumulator, IN and OUT ports.
package nibbler_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/nibble_fifo.sv
// Small circular FIFO with a separate occupancy counter; the push is qualified
// so that a write into a full buffer is only taken when a pop frees a slot in the same cycle.
module nibble_fifo
  import nibbler_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = NIBBLE_W
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_ready_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop     = !empty_o && rd_ready_i;
  // A pop in the same cycle frees the slot the incoming write needs.
  assign push    = wr_en_i && (!full_o || pop);
  assign drop_o  = wr_en_i && !push;

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/nibble_out_port.sv
// OUT-port transmitter: buffers CPU writes and hands them to a consumer,
// dropping writes that find no room and latching a sticky overflow flag.
module nibble_out_port
  import nibbler_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = NIBBLE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic                   overflow,
  input  logic                   ovf_clear
);

  logic empty;
  logic drop;
  logic overflow_q, overflow_d;

  // Handshake: an entry transfers on any rising edge where out_valid and
  // out_ready are both high; out_valid never falls without such a transfer
  // (other than reset), and out_data holds steady until it happens.
  nibble_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_ready_i (out_ready),
    .rd_data_o  (out_data),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .drop_o     (drop)
  );

  assign out_valid = !empty;
  assign overflow  = overflow_q;

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clear) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

endmodule

// File: tb/tb_nibble_out_port.sv
// Directed bench for nibble_out_port: hand-computed vectors, an expected-data
// queue for drain order, and a single summary line.
module tb_nibble_out_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       full;
  logic [2:0] count;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       overflow;
  logic       ovf_clear;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  nibble_out_port #(.DEPTH(4), .DATA_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .count     (count),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input logic [3:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    logic [3:0] e;
    out_ready = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_valid"}, out_valid, 1);
      check_eq({tag, "_data"}, out_data, e);
      step();
    end
    out_ready = 1'b0;
    check_eq({tag, "_empty_valid"}, out_valid, 0);
    check_eq({tag, "_empty_count"}, count, 0);
    check_eq({tag, "_empty_full"}, full, 0);
  endtask

  initial begin
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 4'h0;
    out_ready = 1'b0;
    ovf_clear = 1'b0;
    #2;
    check_eq("rst_count", count, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // single write, held with no consumer
    write_one(4'hA);
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_data", out_data, 4'hA);
    check_eq("t1_count", count, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t1_hold_valid", out_valid, 1);
      check_eq("t1_hold_data", out_data, 4'hA);
      check_eq("t1_hold_count", count, 1);
    end
    exp_q.push_back(4'hA);
    drain_check("t1_drain");

    // ready while empty does nothing
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("idle_ready_count", count, 0);
    check_eq("idle_ready_valid", out_valid, 0);

    // burst of four then drain in order
    for (int i = 1; i <= 4; i++) begin
      write_one(4'(i));
      exp_q.push_back(4'(i));
    end
    check_eq("t2_count", count, 4);
    check_eq("t2_full", full, 1);
    check_eq("t2_ovf", overflow, 0);
    drain_check("t2_drain");

    // fill 5..8 then a dropped write
    for (int i = 5; i <= 8; i++) write_one(4'(i));
    check_eq("t3_full_pre", full, 1);
    check_eq("t3_ovf_pre", overflow, 0);
    write_one(4'hF);
    check_eq("t3_full", full, 1);
    check_eq("t3_ovf", overflow, 1);
    check_eq("t3_count", count, 4);
    check_eq("t3_head", out_data, 4'h5);

    // clear, then push+pop while full
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    check_eq("t4_ovf_cleared", overflow, 0);
    out_ready = 1'b1;
    wr_en     = 1'b1;
    wr_data   = 4'hC;
    step();
    wr_en     = 1'b0;
    out_ready = 1'b0;
    check_eq("t4_count", count, 4);
    check_eq("t4_full", full, 1);
    check_eq("t4_ovf", overflow, 0);
    exp_q.push_back(4'h6);
    exp_q.push_back(4'h7);
    exp_q.push_back(4'h8);
    exp_q.push_back(4'hC);
    drain_check("t4_drain");

    // clear colliding with a drop: set wins
    for (int i = 9; i <= 12; i++) write_one(4'(i));
    write_one(4'h3);
    check_eq("t5_ovf_set", overflow, 1);
    ovf_clear = 1'b1;
    write_one(4'h4);
    check_eq("t5_ovf_set_wins", overflow, 1);
    step();
    ovf_clear = 1'b0;
    check_eq("t5_ovf_clear", overflow, 0);
    check_eq("t5_count", count, 4);
    exp_q.push_back(4'h9);
    exp_q.push_back(4'hA);
    exp_q.push_back(4'hB);
    exp_q.push_back(4'hC);
    drain_check("t5_drain");

    // reset mid-stream, between edges
    write_one(4'hD);
    write_one(4'hE);
    write_one(4'h2);
    write_one(4'h1);
    write_one(4'h6);
    check_eq("t6_pre_count", count, 4);
    check_eq("t6_pre_ovf", overflow, 1);
    #3 reset = 1'b1;
    #1;
    check_eq("t6_rst_valid", out_valid, 0);
    check_eq("t6_rst_count", count, 0);
    check_eq("t6_rst_full", full, 0);
    check_eq("t6_rst_ovf", overflow, 0);
    check_eq("t6_rst_data", out_data, 0);
    step();
    reset = 1'b0;
    write_one(4'h7);
    check_eq("t6_post_valid", out_valid, 1);
    check_eq("t6_post_data", out_data, 4'h7);
    check_eq("t6_post_count", count, 1);
    exp_q.push_back(4'h7);
    drain_check("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
